vscale_dmem_responder: RTL and testbench
========================================

Name: vscale_dmem_responder

Overview:
- HASTI (AHB-Lite subset) slave that terminates the arbitrated dmem bus: a shared word-addressed SRAM serving every core.
- Sits directly downstream of the core arbiter. Accepts a core-index-extended address in the address phase and write data in the following data phase.
- Returns hrdata/hready/hresp with configurable wait states and a two-cycle ERROR response for illegal transfers.

Parameters:
- DEPTH_LOG2, 14, log2 of the number of 32-bit words in the array.
- WAIT_STATES, 0, extra cycles (0..15) that hready is held low in each data phase.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- haddr  in  2+HASTI_ADDR_WIDTH (34)  [33:32] core index, [31:0] byte address
- hwrite  in  1  1 = write transfer
- hsize  in  HASTI_SIZE_WIDTH (3)  0 = byte, 1 = half, 2 = word
- hburst  in  HASTI_BURST_WIDTH (3)  ignored; every transfer is treated as SINGLE
- hmastlock  in  1  ignored
- hprot  in  HASTI_PROT_WIDTH (4)  ignored
- htrans  in  HASTI_TRANS_WIDTH (2)  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- hwdata  in  HASTI_BUS_WIDTH (32)  write data, valid in the data phase
- hrdata  out  32  read data
- hready  out  1  transfer-complete / address accept
- hresp  out  HASTI_RESP_WIDTH (1)  0 OKAY, 1 ERROR
- dphase_core  out  CORE_IDX_WIDTH (2)  core index of the current data phase (verification observability)

Behaviour:
- Reset (reset_n == 0 at a clk edge):
  - State goes to IDLE. hready = 1, hresp = OKAY, hrdata = 0, dphase_core = 0.
  - Any pending data phase is discarded and no write is committed.
  - Array contents are not reset.
- Address-phase accept: occurs when hready == 1 and htrans is NONSEQ or SEQ. BUSY and IDLE are treated as no transfer.
- On accept, register haddr[31:0], haddr[33:32], hwrite and hsize. haddr[33:32] does not affect array indexing (shared memory).
- Legality is checked at accept time. The transfer is illegal if any of these holds:
  - hsize > 2
  - hsize == 1 and addr[0] != 0
  - hsize == 2 and addr[1:0] != 0
  - addr[31:2] >= 2^DEPTH_LOG2
- State machine:
  - IDLE: on a legal accept go to WAIT if WAIT_STATES > 0, else DATA. On an illegal accept go to ERR1. Otherwise stay.
  - WAIT: hready = 0, hresp = OKAY. An internal counter counts down from WAIT_STATES-1; at 0 go to DATA.
  - DATA: hready = 1, hresp = OKAY.
    - Read: hrdata = array[word], full word regardless of hsize; the master extracts lanes.
    - Write: at the clk edge, commit hwdata to the byte lanes given by the mask.
    - Write byte mask: byte -> 1 << addr[1:0]; half -> 0011 << addr[1:0]; word -> 1111.
    - A new accept in the same cycle is handled as from IDLE (back-to-back pipelining). Otherwise go to IDLE.
  - ERR1: hready = 0, hresp = ERROR. Go to ERR2.
  - ERR2: hready = 1, hresp = ERROR. No array access. Accepts a new address as in IDLE.
- Latency:
  - Zero-wait read: data is valid in the cycle after the address phase.
  - A write followed immediately by a read of the same word: the write commits at the DATA-phase edge, and the read's data phase (the next cycle) returns the new value. No bypass is required.
- hrdata = 0 in every state except a read in DATA.
- dphase_core holds the registered core index while in WAIT/DATA/ERR1/ERR2, and holds its last value in IDLE.
- hwdata is sampled only in the DATA cycle; it is don't-care during WAIT.
- Reset asserted during WAIT or DATA: no commit, back to IDLE the next cycle.

Decomposition:
- Shared package/header: extend the existing hasti constants with HASTI_TRANS_IDLE/BUSY/NONSEQ/SEQ, HASTI_SIZE_BYTE/HALF/WORD, HASTI_RESP_OKAY/ERROR, and the state encoding (IDLE, WAIT, DATA, ERR1, ERR2).
- CORE_IDX_WIDTH comes from the multicore constants.
- One sub-module: vscale_sram_bytemask, a 1R1W word array with a 4-bit byte write mask and asynchronous read.

Test Plan:
- Reset, then idle: reset_n = 0 for 2 cycles, then htrans = IDLE -> hready = 1, hresp = 0, hrdata = 0, dphase_core = 0.
- Zero-wait word write then read: write 0xDEADBEEF to haddr 0x0_00000010; next address phase reads 0x10 -> next cycle hrdata = 0xDEADBEEF, hready = 1.
- Byte/half masks: word 0x00000000 at 0x20; byte write 0xAB at 0x22 (hwdata = 0x00AB0000); half write 0x1234 at 0x20 -> read 0x20 returns 0x00AB1234.
- Wait states: WAIT_STATES = 2, read issued at cycle t -> hready = 0 at t+1 and t+2, data valid with hready = 1 at t+3. A second NONSEQ held from t+1 is accepted only at t+3.
- Error: word read at 0x0_00000002 -> hready = 0/hresp = 1 for one cycle, then hready = 1/hresp = 1. A following legal read completes with OKAY.
- Core tag and reset mid-op: write from haddr 0x2_00000040 -> dphase_core = 2 during the data phase. With WAIT_STATES = 3, assert reset_n = 0 during WAIT -> a subsequent read of 0x40 returns the old value.

Source files
------------

// File: rtl/vscale_dmem_responder_pkg.sv
// Shared constants for the dmem responder slice.
// Holds the HASTI (AHB-Lite subset) field widths and encodings, the multicore
// core-index width, the responder state encoding and the byte-lane mask helper.
package vscale_dmem_responder_pkg;

  // HASTI field widths
  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  // Multicore: width of the core index prepended to haddr by the arbiter
  localparam int CORE_IDX_WIDTH = 2;

  // htrans encodings
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

  // hsize encodings
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALF = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD = 3'd2;

  // hresp encodings
  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

  // Responder state encoding
  typedef enum logic [2:0] {
    DMEM_IDLE = 3'd0,
    DMEM_WAIT = 3'd1,
    DMEM_DATA = 3'd2,
    DMEM_ERR1 = 3'd3,
    DMEM_ERR2 = 3'd4
  } dmem_state_e;

  // Byte lanes touched by a write of the given size at the given byte offset.
  // Only called for legal (aligned) transfers, so the shifts never overflow.
  function automatic logic [3:0] hasti_byte_mask(input logic [HASTI_SIZE_WIDTH-1:0] size,
                                                 input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      HASTI_SIZE_BYTE: mask = 4'b0001 << offset;
      HASTI_SIZE_HALF: mask = 4'b0011 << offset;
      default:         mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/vscale_dmem_responder_sram.sv
// vscale_sram_bytemask: word array with one read and one write port.
// Write is synchronous with a 4-bit byte-lane mask; read is asynchronous.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   wmask  in  byte lanes to update when we is high
//   waddr  in  write word index
//   wdata  in  write data
//   raddr  in  read word index
//   rdata  out read data (combinational from raddr)
// Contents are not reset.
module vscale_sram_bytemask #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        wmask,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vscale_dmem_responder.sv
// vscale_dmem_responder: HASTI slave terminating the arbitrated dmem bus.
// A single word-addressed SRAM shared by every core; the core index carried in
// haddr[33:32] is tracked for observability only and never selects memory.
//
// Handshake: an address phase is accepted on a clk edge where hready == 1 and
// htrans is NONSEQ or SEQ (IDLE/BUSY carry no transfer). The data phase that
// follows completes on the first edge where hready == 1 again; hwdata is
// sampled only on that completing edge and hrdata is valid only then.
//
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   haddr         {core index, byte address}
//   hwrite, hsize, htrans   transfer control
//   hburst, hmastlock, hprot  accepted but ignored
//   hwdata        write data (data phase)
//   hrdata        read data, zero except during a read data phase
//   hready, hresp transfer complete / response
//   dphase_core   core index of the current (or last) data phase
module vscale_dmem_responder
  import vscale_dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [CORE_IDX_WIDTH+HASTI_ADDR_WIDTH-1:0] haddr,
  input  logic                                     hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]              hsize,
  input  logic [HASTI_BURST_WIDTH-1:0]             hburst,
  input  logic                                     hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]              hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0]             htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]               hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]               hrdata,
  output logic                                     hready,
  output logic [HASTI_RESP_WIDTH-1:0]              hresp,
  output logic [CORE_IDX_WIDTH-1:0]                dphase_core
);

  // Counter preload: WAIT lasts WAIT_STATES cycles, leaving at count 0.
  localparam logic [3:0]  WAIT_LOAD    = 4'(WAIT_STATES - 1);
  localparam dmem_state_e FIRST_DPHASE = (WAIT_STATES > 0) ? DMEM_WAIT : DMEM_DATA;

  dmem_state_e state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  // Data-phase context captured at address accept
  logic [DEPTH_LOG2+1:0]       addr_q;
  logic [CORE_IDX_WIDTH-1:0]   core_q;
  logic                        write_q;
  logic [HASTI_SIZE_WIDTH-1:0] size_q;

  logic [HASTI_ADDR_WIDTH-1:0] req_addr;
  logic                        trans_active;
  logic                        accept;
  logic                        req_legal;

  logic                        mem_we;
  logic [3:0]                  mem_wmask;
  logic [31:0]                 mem_rdata;

  logic                        unused_ok;

  // Size, alignment and range check of an address-phase request.
  function automatic logic xfer_legal(input logic [HASTI_ADDR_WIDTH-1:0] a,
                                      input logic [HASTI_SIZE_WIDTH-1:0] sz);
    logic size_ok, align_ok, range_ok;
    size_ok  = (sz <= HASTI_SIZE_WORD);
    align_ok = !((sz == HASTI_SIZE_HALF && a[0]) ||
                 (sz == HASTI_SIZE_WORD && a[1:0] != 2'b00));
    // Any set bit above the word index means the word is beyond the array.
    range_ok = ((a >> (DEPTH_LOG2 + 2)) == '0);
    return size_ok && align_ok && range_ok;
  endfunction

  assign req_addr     = haddr[HASTI_ADDR_WIDTH-1:0];
  assign trans_active = (htrans == HASTI_TRANS_NONSEQ) || (htrans == HASTI_TRANS_SEQ);
  assign accept       = hready && trans_active;
  assign req_legal    = xfer_legal(req_addr, hsize);

  // Bus response: a function of state only
  always_comb begin
    hready = 1'b1;
    hresp  = HASTI_RESP_OKAY;
    case (state_q)
      DMEM_WAIT: hready = 1'b0;
      DMEM_ERR1: begin
        hready = 1'b0;
        hresp  = HASTI_RESP_ERROR;
      end
      DMEM_ERR2: hresp = HASTI_RESP_ERROR;
      default: ;
    endcase
  end

  // Next state. IDLE, DATA and ERR2 all drive hready high and so all accept a
  // new address the same way, which gives back-to-back pipelining.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      DMEM_IDLE, DMEM_DATA, DMEM_ERR2: begin
        state_d = DMEM_IDLE;
        if (accept) begin
          state_d    = req_legal ? FIRST_DPHASE : DMEM_ERR1;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      DMEM_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = DMEM_DATA;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      DMEM_ERR1: state_d = DMEM_ERR2;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= DMEM_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      core_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        addr_q  <= req_addr[DEPTH_LOG2+1:0];
        core_q  <= haddr[CORE_IDX_WIDTH+HASTI_ADDR_WIDTH-1:HASTI_ADDR_WIDTH];
        write_q <= hwrite;
        size_q  <= hsize;
      end
    end
  end

  // Commit only on the DATA edge; reset on that edge cancels the write.
  assign mem_we    = (state_q == DMEM_DATA) && write_q && reset_n;
  assign mem_wmask = hasti_byte_mask(size_q, addr_q[1:0]);

  vscale_sram_bytemask #(
    .ADDR_W (DEPTH_LOG2)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .wmask (mem_wmask),
    .waddr (addr_q[DEPTH_LOG2+1:2]),
    .wdata (hwdata),
    .raddr (addr_q[DEPTH_LOG2+1:2]),
    .rdata (mem_rdata)
  );

  // Full word returned regardless of hsize; the master picks the lanes.
  assign hrdata      = (state_q == DMEM_DATA && !write_q) ? mem_rdata : '0;
  assign dphase_core = core_q;

  assign unused_ok = ^{hburst, hmastlock, hprot};

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: three instances (0, 2 and 3 wait states)
// share one driver; only the selected instance sees live htrans. A
// transaction-level model predicts every cycle's response from the transfer's
// age in its data phase and a plain word array.
module tb_vscale_dmem_responder;
  import vscale_dmem_responder_pkg::*;

  localparam int DL2    = 6;
  localparam int NWORDS = 1 << DL2;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [33:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;

  logic [1:0]  htrans_d [3];
  logic [31:0] hrdata_d [3];
  logic        hready_d [3];
  logic        hresp_d  [3];
  logic [1:0]  core_d   [3];

  int sel;
  int ws;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = ws_of(g);
    assign htrans_d[g] = (sel == g) ? htrans : HASTI_TRANS_IDLE;
    vscale_dmem_responder #(
      .DEPTH_LOG2  (DL2),
      .WAIT_STATES (WS)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .haddr       (haddr),
      .hwrite      (hwrite),
      .hsize       (hsize),
      .hburst      (hburst),
      .hmastlock   (hmastlock),
      .hprot       (hprot),
      .htrans      (htrans_d[g]),
      .hwdata      (hwdata),
      .hrdata      (hrdata_d[g]),
      .hready      (hready_d[g]),
      .hresp       (hresp_d[g]),
      .dphase_core (core_d[g])
    );
  end

  // ---------------- model state ----------------
  typedef struct {
    logic [1:0]  core;
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       pend_q[$];
  logic [31:0] exp_q[$];
  bit          dp_valid;
  xfer_t       dp;
  int          dp_cyc;
  bit          dp_legal;
  logic [1:0]  exp_core;
  logic [31:0] model_mem [3][NWORDS];
  logic [31:0] last_rd;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d t=%0t): got 0x%08h expected 0x%08h", tag, sel, $time, got, exp);
    end
  endtask

  function automatic bit is_legal(input xfer_t t);
    if (t.size > 3'd2) return 1'b0;
    if (t.size == 3'd1 && (t.addr % 2) != 0) return 1'b0;
    if (t.size == 3'd2 && (t.addr % 4) != 0) return 1'b0;
    if ((t.addr / 4) >= 32'(NWORDS)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_write(input xfer_t t);
    int w, off;
    bit hit;
    w   = int'(t.addr / 4);
    off = int'(t.addr % 4);
    for (int b = 0; b < 4; b++) begin
      case (t.size)
        3'd0:    hit = (b == off);
        3'd1:    hit = (b == off) || (b == off + 1);
        default: hit = 1'b1;
      endcase
      if (hit) model_mem[sel][w][8*b +: 8] = t.wdata[8*b +: 8];
    end
  endtask

  // ---------------- driver ----------------
  task automatic push(input logic [1:0] core, input logic [31:0] addr, input bit wr,
                      input logic [2:0] size, input logic [31:0] wdata);
    xfer_t t;
    t.core = core; t.addr = addr; t.wr = wr; t.size = size; t.wdata = wdata;
    pend_q.push_back(t);
  endtask

  // One bus cycle; entered and left 1 time unit after a rising edge.
  task automatic tick(input bit gap);
    bit          active, completes;
    logic        exp_ready, exp_resp;
    logic [31:0] exp_rd;
    active    = !gap && (pend_q.size() > 0);
    completes = dp_valid && dp_legal && (dp_cyc == ws);
    if (active) begin
      htrans = $urandom_range(0, 1) ? HASTI_TRANS_SEQ : HASTI_TRANS_NONSEQ;
      haddr  = {pend_q[0].core, pend_q[0].addr};
      hwrite = pend_q[0].wr;
      hsize  = pend_q[0].size;
    end else begin
      htrans = $urandom_range(0, 1) ? HASTI_TRANS_BUSY : HASTI_TRANS_IDLE;
      haddr  = {2'($urandom_range(0, 3)), 32'($urandom)};
      hwrite = 1'($urandom_range(0, 1));
      hsize  = 3'($urandom_range(0, 7));
    end
    hburst    = 3'($urandom_range(0, 7));
    hprot     = 4'($urandom_range(0, 15));
    hmastlock = 1'($urandom_range(0, 1));
    hwdata    = (completes && dp.wr) ? dp.wdata : 32'($urandom);

    @(negedge clk);
    if (!dp_valid) begin
      exp_ready = 1'b1; exp_resp = 1'b0;
    end else if (!dp_legal) begin
      exp_ready = (dp_cyc != 0); exp_resp = 1'b1;
    end else begin
      exp_ready = (dp_cyc == ws); exp_resp = 1'b0;
    end
    exp_rd = 32'h0;
    if (completes && !dp.wr) begin
      exp_q.push_back(model_mem[sel][dp.addr / 4]);
      exp_rd  = exp_q.pop_front();
      last_rd = hrdata_d[sel];
    end
    check_eq("hready", {31'h0, hready_d[sel]}, {31'h0, exp_ready});
    check_eq("hresp", {31'h0, hresp_d[sel]}, {31'h0, exp_resp});
    check_eq("hrdata", hrdata_d[sel], exp_rd);
    check_eq("dphase_core", {30'h0, core_d[sel]}, {30'h0, exp_core});

    @(posedge clk);
    if (exp_ready) begin
      if (completes && dp.wr) model_write(dp);
      if (active) begin
        dp       = pend_q.pop_front();
        dp_valid = 1'b1;
        dp_cyc   = 0;
        dp_legal = is_legal(dp);
        exp_core = dp.core;
      end else begin
        dp_valid = 1'b0;
      end
    end else begin
      dp_cyc++;
    end
    #1;
  endtask

  task automatic drain(input int max_cycles, input bit gaps);
    int c;
    c = 0;
    while ((pend_q.size() > 0 || dp_valid) && c < max_cycles) begin
      tick(gaps ? ($urandom_range(0, 3) == 0) : 1'b0);
      c++;
    end
    if (pend_q.size() > 0 || dp_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout (dut%0d): %0d transfers still pending after %0d cycles",
               sel, pend_q.size(), c);
      pend_q.delete();
      dp_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    htrans  = HASTI_TRANS_IDLE;
    repeat (n) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    dp_valid = 1'b0;
    exp_core = 2'd0;
    pend_q.delete();
  endtask

  task automatic push_random();
    logic [2:0]  sz;
    logic [31:0] a;
    int          r;
    r = $urandom_range(0, 9);
    if (r < 3)      sz = 3'd0;
    else if (r < 6) sz = 3'd1;
    else if (r < 9) sz = 3'd2;
    else            sz = 3'($urandom_range(3, 7));
    if ($urandom_range(0, 9) == 0) begin
      a = 32'($urandom);
    end else begin
      a = 32'($urandom_range(0, NWORDS - 1)) * 4;
      if ($urandom_range(0, 9) == 0)  a += 32'($urandom_range(0, 3));
      else if (sz == 3'd0)            a += 32'($urandom_range(0, 3));
      else if (sz == 3'd1)            a += 32'($urandom_range(0, 1)) * 2;
    end
    push(2'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)), sz, 32'($urandom));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    haddr     = '0;
    hwrite    = 1'b0;
    hsize     = '0;
    hburst    = '0;
    hmastlock = 1'b0;
    hprot     = '0;
    htrans    = HASTI_TRANS_IDLE;
    hwdata    = '0;
    sel       = 0;
    ws        = 0;
    dp_valid  = 1'b0;
    dp_cyc    = 0;
    dp_legal  = 1'b0;
    exp_core  = 2'd0;
    last_rd   = '0;
    @(posedge clk);
    #1;

    for (int d = 0; d < 3; d++) begin
      sel = d;
      ws  = ws_of(d);
      do_reset(2);
      tick(1'b1);
      tick(1'b1);

      // Known contents for every word
      for (int w = 0; w < NWORDS; w++) push(2'($urandom_range(0, 3)), 32'(w * 4), 1'b1, 3'd2, 32'($urandom));
      drain(2000, 1'b0);

      if (d == 0) begin
        push(2'd0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        push(2'd0, 32'h10, 1'b0, 3'd2, 32'h0);
        drain(100, 1'b0);
        check_eq("rd_deadbeef", last_rd, 32'hDEADBEEF);

        push(2'd0, 32'h20, 1'b1, 3'd2, 32'h00000000);
        push(2'd0, 32'h22, 1'b1, 3'd0, 32'h00AB0000);
        push(2'd0, 32'h20, 1'b1, 3'd1, 32'h00001234);
        push(2'd0, 32'h20, 1'b0, 3'd2, 32'h0);
        drain(100, 1'b0);
        check_eq("rd_bytemask", last_rd, 32'h00AB1234);

        // Illegal transfers back to back with legal ones
        push(2'd1, 32'h2,   1'b0, 3'd2, 32'h0);
        push(2'd1, 32'h14,  1'b0, 3'd2, 32'h0);
        push(2'd3, 32'h21,  1'b1, 3'd1, 32'h0);
        push(2'd2, 32'h24,  1'b0, 3'd3, 32'h0);
        push(2'd0, 32'h100, 1'b0, 3'd2, 32'h0);
        push(2'd0, 32'hFC,  1'b1, 3'd2, 32'h0BADF00D);
        push(2'd0, 32'hFC,  1'b0, 3'd2, 32'h0);
        drain(100, 1'b0);
        check_eq("rd_top_word", last_rd, 32'h0BADF00D);

        // Reset in the DATA cycle of a write cancels the write
        push(2'd0, 32'h44, 1'b1, 3'd2, 32'h11111111);
        drain(100, 1'b0);
        push(2'd0, 32'h44, 1'b1, 3'd2, 32'h22222222);
        tick(1'b0);
        do_reset(1);
        tick(1'b1);
        push(2'd0, 32'h44, 1'b0, 3'd2, 32'h0);
        drain(100, 1'b0);
        check_eq("rst_in_data", last_rd, 32'h11111111);
      end else if (d == 1) begin
        // Pipelined reads and writes held through the wait states
        push(2'd1, 32'h30, 1'b1, 3'd2, 32'hA5A5A5A5);
        push(2'd2, 32'h30, 1'b0, 3'd2, 32'h0);
        push(2'd3, 32'h2,  1'b0, 3'd2, 32'h0);
        push(2'd0, 32'h30, 1'b0, 3'd2, 32'h0);
        drain(100, 1'b0);
        check_eq("rd_ws2", last_rd, 32'hA5A5A5A5);
      end else begin
        // Core tag, then reset during WAIT cancels the write
        push(2'd2, 32'h40, 1'b1, 3'd2, 32'h55AA55AA);
        drain(100, 1'b0);
        push(2'd2, 32'h40, 1'b1, 3'd2, 32'hCAFEF00D);
        tick(1'b0);
        tick(1'b1);
        do_reset(1);
        tick(1'b1);
        push(2'd1, 32'h40, 1'b0, 3'd2, 32'h0);
        drain(100, 1'b0);
        check_eq("rst_in_wait", last_rd, 32'h55AA55AA);
      end

      for (int k = 0; k < 150; k++) push_random();
      drain(3000, 1'b1);
      tick(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
